// File: rtl/mio_arbiter.sv
// rtl/mio_arbiter.sv - two-master round-robin arbiter onto one memory port with ack timeout
module mio_arbiter #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_ready,
   output logic [31:0] cpu_rdata,
   input  logic        dev_req,
   input  logic        dev_we,
   input  logic [31:0] dev_addr,
   input  logic [31:0] dev_wdata,
   output logic        dev_ready,
   output logic [31:0] dev_rdata,
   output logic        mem_en,
   output logic        mem_w,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [1:0]  grant,
   output logic        bus_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Count value seen in the last BUSY cycle before an unacknowledged access aborts.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q;
   logic        owner_q;      // 0 = CPU, 1 = device
   logic        last_q;       // last served: 0 = CPU, 1 = device
   logic        we_q;
   logic        err_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] cpu_rdata_q;
   logic [31:0] dev_rdata_q;
   logic [7:0]  cnt_q;

   logic        start_d;
   logic        win_dev_d;
   logic        expire_d;

   // Pick the winner in IDLE; a tie goes to whoever was not served last.
   always_comb begin
      start_d   = cpu_req | dev_req;
      win_dev_d = dev_req;
      if (cpu_req && dev_req) begin
         win_dev_d = ~last_q;
      end
      expire_d  = (cnt_q == CNT_LAST);
   end

   // Access sequencer: latch the winner's request, wait for ack or timeout, give one ready pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         owner_q     <= 1'b0;
         last_q      <= 1'b1;
         we_q        <= 1'b0;
         err_q       <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         cpu_rdata_q <= 32'd0;
         dev_rdata_q <= 32'd0;
         cnt_q       <= 8'd0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start_d) begin
                  owner_q <= win_dev_d;
                  we_q    <= win_dev_d ? dev_we    : cpu_we;
                  addr_q  <= win_dev_d ? dev_addr  : cpu_addr;
                  wdata_q <= win_dev_d ? dev_wdata : cpu_wdata;
                  cnt_q   <= 8'd0;
                  err_q   <= 1'b0;
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (mem_ack) begin
                  if (!we_q) begin
                     if (owner_q) begin
                        dev_rdata_q <= mem_rdata;
                     end else begin
                        cpu_rdata_q <= mem_rdata;
                     end
                  end
                  err_q   <= 1'b0;
                  state_q <= ST_RESP;
               end else if (expire_d) begin
                  err_q   <= 1'b1;
                  state_q <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            ST_RESP: begin
               last_q  <= owner_q;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign mem_en    = (state_q == ST_BUSY);
   assign mem_w     = (state_q == ST_BUSY) & we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign grant     = (state_q == ST_IDLE) ? 2'b00 : {owner_q, ~owner_q};
   assign cpu_ready = (state_q == ST_RESP) & ~owner_q;
   assign dev_ready = (state_q == ST_RESP) & owner_q;
   assign bus_err   = (state_q == ST_RESP) & err_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dev_rdata = dev_rdata_q;

endmodule

// File: tb/tb_mio_arbiter.sv
// tb/tb_mio_arbiter.sv - directed and randomized checks of mio_arbiter against a transaction model
module tb_mio_arbiter;

   localparam int TMO = 15;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic        dev_req = 1'b0, dev_we = 1'b0;
   logic [31:0] dev_addr = '0, dev_wdata = '0;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic        cpu_ready, dev_ready, mem_en, mem_w, bus_err;
   logic [31:0] cpu_rdata, dev_rdata, mem_addr, mem_wdata;
   logic [1:0]  grant;

   int n_checks = 0;
   int n_errors = 0;
   bit run_cmp  = 1'b0;

   mio_arbiter #(.TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
      .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
      .dev_ready(dev_ready), .dev_rdata(dev_rdata),
      .mem_en(mem_en), .mem_w(mem_w), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .grant(grant), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Transaction-level model: who owns the bus, how many BUSY cycles have elapsed,
   // what was latched at grant time, and the per-requester read-data history.
   int          m_owner  = 0;     // 0 = CPU, 1 = device
   int          m_last   = 1;     // last served requester
   bit          m_busy   = 1'b0;
   bit          m_resp   = 1'b0;
   int          m_cycles = 0;
   bit          m_we     = 1'b0;
   bit          m_err    = 1'b0;
   logic [31:0] m_addr   = '0;
   logic [31:0] m_wdata  = '0;
   logic [31:0] m_cpu_rd = '0;
   logic [31:0] m_dev_rd = '0;

   function automatic int pick(input bit c, input bit d, input int last);
      if (c && d) return 1 - last;
      return d ? 1 : 0;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_owner <= 0; m_last <= 1; m_busy <= 1'b0; m_resp <= 1'b0; m_cycles <= 0;
         m_we <= 1'b0; m_err <= 1'b0; m_addr <= '0; m_wdata <= '0;
         m_cpu_rd <= '0; m_dev_rd <= '0;
      end else if (m_resp) begin
         m_resp <= 1'b0;
         m_last <= m_owner;
      end else if (m_busy) begin
         m_cycles <= m_cycles + 1;
         if (mem_ack) begin
            if (!m_we && m_owner == 1) m_dev_rd <= mem_rdata;
            if (!m_we && m_owner == 0) m_cpu_rd <= mem_rdata;
            m_err  <= 1'b0;
            m_busy <= 1'b0;
            m_resp <= 1'b1;
         end else if (m_cycles + 1 == TMO) begin
            m_err  <= 1'b1;
            m_busy <= 1'b0;
            m_resp <= 1'b1;
         end
      end else if (cpu_req || dev_req) begin
         m_owner  <= pick(cpu_req, dev_req, m_last);
         m_we     <= (pick(cpu_req, dev_req, m_last) == 1) ? dev_we    : cpu_we;
         m_addr   <= (pick(cpu_req, dev_req, m_last) == 1) ? dev_addr  : cpu_addr;
         m_wdata  <= (pick(cpu_req, dev_req, m_last) == 1) ? dev_wdata : cpu_wdata;
         m_busy   <= 1'b1;
         m_cycles <= 0;
      end
   end

   // Every mid-cycle, compare the DUT against the model.
   always @(negedge clk) begin
      if (reset && run_cmp) begin
         chk("m_mem_en", {31'd0, mem_en}, {31'd0, m_busy});
         chk("m_cpu_ready", {31'd0, cpu_ready}, {31'd0, m_resp && m_owner == 0});
         chk("m_dev_ready", {31'd0, dev_ready}, {31'd0, m_resp && m_owner == 1});
         chk("m_cpu_rdata", cpu_rdata, m_cpu_rd);
         chk("m_dev_rdata", dev_rdata, m_dev_rd);
         if (m_busy) begin
            chk("m_grant_busy", {30'd0, grant}, (m_owner == 1) ? 32'd2 : 32'd1);
            chk("m_mem_w", {31'd0, mem_w}, {31'd0, m_we});
            chk("m_mem_addr", mem_addr, m_addr);
            chk("m_mem_wdata", mem_wdata, m_wdata);
         end else if (m_resp) begin
            chk("m_bus_err", {31'd0, bus_err}, {31'd0, m_err});
         end else begin
            chk("m_grant_idle", {30'd0, grant}, 32'd0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [1:0] rr_exp [4];
      int nb;
      bit seen;
      int pct;
      rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;

      // Reset values
      repeat (3) cyc();
      chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("rst_grant", {30'd0, grant}, 32'd0);
      chk("rst_cpu_rdata", cpu_rdata, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);

      // Round-robin with both requests held and immediate ack
      reset = 1'b1; run_cmp = 1'b1;
      cpu_req = 1'b1; dev_req = 1'b1; cpu_addr = 32'h10; dev_addr = 32'h20;
      mem_ack = 1'b1; mem_rdata = 32'h0000BEEF;
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("rr_grant", {30'd0, grant}, {30'd0, rr_exp[k]});
         cyc();
         chk("rr_cpu_ready", {31'd0, cpu_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_dev_ready", {31'd0, dev_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
         if (k == 3) begin cpu_req = 1'b0; dev_req = 1'b0; mem_ack = 1'b0; end
         cyc();
      end

      // CPU read, ack in the first BUSY cycle
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4; mem_ack = 1'b1; mem_rdata = 32'h42000018;
      cyc();
      chk("rd_mem_en", {31'd0, mem_en}, 32'd1);
      chk("rd_grant", {30'd0, grant}, 32'd1);
      chk("rd_mem_addr", mem_addr, 32'h4);
      cyc();
      chk("rd_cpu_ready", {31'd0, cpu_ready}, 32'd1);
      chk("rd_bus_err", {31'd0, bus_err}, 32'd0);
      chk("rd_mem_en_off", {31'd0, mem_en}, 32'd0);
      chk("rd_cpu_rdata", cpu_rdata, 32'h42000018);
      chk("model_cpu_rd", m_cpu_rd, 32'h42000018);
      cpu_req = 1'b0; mem_ack = 1'b0;
      cyc();
      chk("rd_ready_single", {31'd0, cpu_ready}, 32'd0);

      // Device write acked in the third BUSY cycle; inputs change under it
      dev_req = 1'b1; dev_we = 1'b1; dev_addr = 32'h100; dev_wdata = 32'h12345678;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("wr_mem_en", {31'd0, mem_en}, 32'd1);
         chk("wr_mem_w", {31'd0, mem_w}, 32'd1);
         chk("wr_mem_addr", mem_addr, 32'h100);
         chk("wr_mem_wdata", mem_wdata, 32'h12345678);
         if (i == 0) begin dev_addr = 32'hFFFFFFFF; dev_wdata = 32'h0; dev_we = 1'b0; end
         if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'hDEADDEAD; end
      end
      cyc();
      chk("wr_dev_ready", {31'd0, dev_ready}, 32'd1);
      chk("wr_bus_err", {31'd0, bus_err}, 32'd0);
      chk("wr_dev_rdata", dev_rdata, 32'h0000BEEF);
      dev_req = 1'b0; mem_ack = 1'b0;
      cyc();

      // Timeout: CPU read never acked
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8; mem_rdata = 32'h11111111;
      nb = 0; seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         cyc();
         if (mem_en) nb++;
         if (cpu_ready) begin
            seen = 1'b1;
            chk("tmo_bus_err", {31'd0, bus_err}, 32'd1);
         end
      end
      chk("tmo_ready_seen", {31'd0, seen}, 32'd1);
      chk("tmo_busy_cycles", nb, TMO);
      chk("tmo_cpu_rdata", cpu_rdata, 32'h42000018);
      cpu_req = 1'b0;
      cyc();

      // Abort by reset in the second BUSY cycle, then re-grant of the held request
      cpu_req = 1'b1;
      cyc();
      cyc();
      chk("ab_mem_en", {31'd0, mem_en}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("ab_mem_en_async", {31'd0, mem_en}, 32'd0);
      chk("ab_grant_async", {30'd0, grant}, 32'd0);
      chk("ab_mem_addr", mem_addr, 32'd0);
      chk("ab_mem_wdata", mem_wdata, 32'd0);
      chk("ab_mem_w", {31'd0, mem_w}, 32'd0);
      chk("ab_ready", {30'd0, cpu_ready, dev_ready}, 32'd0);
      chk("ab_bus_err", {31'd0, bus_err}, 32'd0);
      chk("ab_cpu_rdata", cpu_rdata, 32'd0);
      chk("ab_dev_rdata", dev_rdata, 32'd0);
      repeat (2) begin
         cyc();
         chk("ab_no_ready", {31'd0, cpu_ready}, 32'd0);
      end
      reset = 1'b1;
      cyc();
      chk("ab_regrant", {30'd0, grant}, 32'd1);
      chk("ab_regrant_en", {31'd0, mem_en}, 32'd1);
      mem_ack = 1'b1;
      cyc();
      chk("ab_ready_after", {31'd0, cpu_ready}, 32'd1);
      cpu_req = 1'b0; mem_ack = 1'b0;
      cyc();

      // Randomized traffic: requesters hold req until they see their ready
      for (int c = 0; c < 3000; c++) begin
         pct = (c < 1000) ? 60 : (c < 2000) ? 20 : 4;
         if (cpu_req && cpu_ready) cpu_req = 1'b0;
         else if (!cpu_req && $urandom_range(0, 99) < 40) cpu_req = 1'b1;
         if (dev_req && dev_ready) dev_req = 1'b0;
         else if (!dev_req && $urandom_range(0, 99) < 40) dev_req = 1'b1;
         cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
         dev_we = 1'($urandom); dev_addr = $urandom; dev_wdata = $urandom;
         mem_ack = ($urandom_range(0, 99) < pct);
         mem_rdata = $urandom;
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
